// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM encoding shared by the serial ALU responder
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Subtraction is a + ~b + 1, so the serial carry starts at 1.
  function automatic logic preset_carry(input logic [1:0] op);
    return op == OP_SUB;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit add/sub/or/xor cell with carry in/out
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  logic bb;

  always_comb begin
    bb   = (op == OP_SUB) ? ~b : b;
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        s    = a ^ bb ^ cin;
        cout = (a & bb) | (a & cin) | (bb & cin);
      end
      OP_OR:   s = a | b;
      default: s = a ^ b;
    endcase
  end

endmodule

// File: rtl/serial_alu_resp.sv
// rtl/serial_alu_resp.sv - bit-serial handshaked ALU responder, LSB first
// Optional carry_out port enabled by SERIAL_ALU_CARRY_OUT_EN.
module serial_alu_resp
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [1:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SERIAL_ALU_CARRY_OUT_EN
  output logic         carry_out,
`endif
  output logic [N-1:0] out
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     res_q, res_d;
  logic [N-1:0]     out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
`ifdef SERIAL_ALU_CARRY_OUT_EN
  logic             carry_out_q, carry_out_d;
`endif

  logic slice_s;
  logic slice_cout;

  alu_bit_slice u_slice (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    carry_d     = carry_q;
    res_d       = res_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef SERIAL_ALU_CARRY_OUT_EN
    carry_out_d = carry_out_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in0;
          b_d        = in1;
          op_d       = opcode;
          carry_d    = preset_carry(opcode);
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        res_d[cnt_q] = slice_s;
        carry_d      = slice_cout;
        cnt_d        = cnt_q + CNT_W'(1);
        // The visible result register is loaded only once the last bit is known.
        if (cnt_q == CNT_LAST) begin
          out_d       = res_d;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SERIAL_ALU_CARRY_OUT_EN
          carry_out_d = slice_cout;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      res_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SERIAL_ALU_CARRY_OUT_EN
      carry_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SERIAL_ALU_CARRY_OUT_EN
      carry_out_q <= carry_out_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
`ifdef SERIAL_ALU_CARRY_OUT_EN
  assign carry_out = carry_out_q;
`endif

endmodule

// File: tb/tb_serial_alu_resp.sv
// tb/tb_serial_alu_resp.sv - randomized self-checking bench for serial_alu_resp (N=4)
module tb_serial_alu_resp;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in0 = '0;
  logic [N-1:0] in1 = '0;
  logic [1:0]   opcode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out;
`ifdef SERIAL_ALU_CARRY_OUT_EN
  logic         carry_out;
`endif

  int checks = 0;
  int errors = 0;

  serial_alu_resp #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SERIAL_ALU_CARRY_OUT_EN
    .carry_out (carry_out),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_res(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = (a + b) % 16;
      1:       r = (a - b + 16) % 16;
      2:       r = a | b;
      default: r = a ^ b;
    endcase
    return N'(r);
  endfunction

  function automatic logic model_cy(input int a, input int b, input int op);
    if (op == 0) return (a + b) > 15;
    if (op == 1) return a >= b;
    return 1'b0;
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                        input int dly, output logic [N-1:0] res, output logic cy,
                        output int lat, output logic busy_leak);
    logic [N-1:0] prev;
    int t;
    prev = out;
    busy_leak = 1'b0;
    in0 = a; in1 = b; opcode = op; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (out !== prev) busy_leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = out;
`ifdef SERIAL_ALU_CARRY_OUT_EN
    cy = carry_out;
`else
    cy = 1'b0;
`endif
    repeat (dly) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in0 = 4'hF; in1 = 4'h1; opcode = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h required 1 0 0", in_ready, out_valid, out);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 4'h0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b out=%h required 1 0 0", in_ready, out_valid, out);
    end
  endtask

  task automatic test_add_wrap();
    logic [N-1:0] r; logic cy; int lat; logic leak;
    run_op(4'b1111, 4'b0001, 2'b00, 0, r, cy, lat, leak);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d required 4", lat); end
    checks++;
    if (r !== 4'b0000) begin errors++; $display("FAIL add_wrap: got %b required 0000", r); end
`ifdef SERIAL_ALU_CARRY_OUT_EN
    checks++;
    if (cy !== 1'b1) begin errors++; $display("FAIL add_carry: got %b required 1", cy); end
`endif
  endtask

  task automatic test_sub_borrow();
    logic [N-1:0] r; logic cy; int lat; logic leak;
    run_op(4'b0011, 4'b0101, 2'b01, 1, r, cy, lat, leak);
    checks++;
    if (r !== 4'b1110) begin errors++; $display("FAIL sub_borrow: got %b required 1110", r); end
    checks++;
    if (leak !== 1'b0) begin errors++; $display("FAIL sub_busy_out: partial result visible, got %b required 0", leak); end
`ifdef SERIAL_ALU_CARRY_OUT_EN
    checks++;
    if (cy !== 1'b0) begin errors++; $display("FAIL sub_carry: got %b required 0", cy); end
`endif
    run_op(4'b0000, 4'b0001, 2'b01, 0, r, cy, lat, leak);
    checks++;
    if (r !== 4'b1111) begin errors++; $display("FAIL sub_wrap: got %b required 1111", r); end
  endtask

  task automatic test_logic();
    logic [N-1:0] r; logic cy; int lat; logic leak;
    run_op(4'b1100, 4'b1010, 2'b10, 0, r, cy, lat, leak);
    checks++;
    if (r !== 4'b1110) begin errors++; $display("FAIL or_op: got %b required 1110", r); end
    run_op(4'b1100, 4'b1010, 2'b11, 2, r, cy, lat, leak);
    checks++;
    if (r !== 4'b0110) begin errors++; $display("FAIL xor_op: got %b required 0110", r); end
    checks++;
    if (leak !== 1'b0) begin errors++; $display("FAIL xor_busy_out: partial result visible, got %b required 0", leak); end
`ifdef SERIAL_ALU_CARRY_OUT_EN
    checks++;
    if (cy !== 1'b0) begin errors++; $display("FAIL xor_carry: got %b required 0", cy); end
`endif
  endtask

  task automatic test_backpressure();
    int t;
    in0 = 4'd9; in1 = 4'd5; opcode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: out_valid=%b required 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; in0 = 4'($urandom); in1 = 4'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out !== 4'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out=%h out_valid=%b in_ready=%b required e 1 0", i, out, out_valid, in_ready);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 4'd14) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b out=%h required 0 1 e", out_valid, in_ready, out);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept_in_done: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_midop_reset();
    logic seen;
    in0 = 4'd3; in1 = 4'd4; opcode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 4'h0) begin
      errors++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b out=%h required 1 0 0", in_ready, out_valid, out);
    end
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_output: out_valid seen=%b required 0", seen); end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, r; logic [1:0] op; logic cy; int lat; logic leak;
    for (int i = 0; i < 100; i++) begin
      a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
      run_op(a, b, op, $urandom_range(0, 3), r, cy, lat, leak);
      checks++;
      if (r !== model_res(a, b, op) || lat !== N || leak !== 1'b0) begin
        errors++;
        $display("FAIL rand[%0d] a=%h b=%h op=%0d: out=%h lat=%0d leak=%b required out=%h lat=%0d leak=0",
                 i, a, b, op, r, lat, leak, model_res(a, b, op), N);
      end
`ifdef SERIAL_ALU_CARRY_OUT_EN
      checks++;
      if (cy !== model_cy(a, b, op)) begin
        errors++;
        $display("FAIL rand_carry[%0d]: got %b required %b", i, cy, model_cy(a, b, op));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_borrow();
    test_logic();
    test_backpressure();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
